// File: rtl/branch_target_table_if.sv
// Lookup, table-update and statistics signals of the branch target table.
// The master drives requests and updates; the slave is the table itself.
interface branch_target_table_if #(
   parameter int unsigned PC_W   = 12,
   parameter int unsigned KEY_W  = 5,
   parameter int unsigned PROG_W = 2,
   parameter int unsigned CNT_W  = 16
);
   logic              lookup_en;
   logic [PROG_W-1:0] program_num;
   logic [KEY_W-1:0]  key;
   logic [PC_W-1:0]   branch_pos;
   logic              branch_valid;
   logic              branch_hit;
   logic              wr_en;
   logic [PROG_W-1:0] wr_prog;
   logic [KEY_W-1:0]  wr_key;
   logic [PC_W-1:0]   wr_pos;
   logic              clr_en;
   logic [PROG_W-1:0] clr_prog;
   logic              stat_clr;
   logic [CNT_W-1:0]  hit_cnt;
   logic [CNT_W-1:0]  miss_cnt;

   modport master (
      output lookup_en, program_num, key,
      output wr_en, wr_prog, wr_key, wr_pos,
      output clr_en, clr_prog, stat_clr,
      input  branch_pos, branch_valid, branch_hit, hit_cnt, miss_cnt
   );

   modport slave (
      input  lookup_en, program_num, key,
      input  wr_en, wr_prog, wr_key, wr_pos,
      input  clr_en, clr_prog, stat_clr,
      output branch_pos, branch_valid, branch_hit, hit_cnt, miss_cnt
   );
endinterface

// File: rtl/branch_target_table.sv
// Loadable multi-bank branch target table with registered lookup, same-cycle
// write bypass, whole-bank clear and saturating hit/miss counters.
module branch_target_table #(
   parameter int unsigned     PC_W        = 12,
   parameter int unsigned     KEY_W       = 5,
   parameter int unsigned     NUM_PROG    = 4,
   parameter logic [PC_W-1:0] DEFAULT_POS = '0,
   parameter int unsigned     CNT_W       = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   branch_target_table_if.slave  bus
);
   localparam int unsigned NUM_KEYS = 2 ** KEY_W;
   localparam int unsigned PROG_W   = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1;
   localparam int unsigned NUM_ENT  = NUM_PROG * NUM_KEYS;
   localparam int unsigned IDX_W    = $clog2(NUM_ENT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [IDX_W-1:0] ent_idx(input logic [PROG_W-1:0] prog,
                                                input logic [KEY_W-1:0]  k);
      return IDX_W'(32'(prog) * NUM_KEYS + 32'(k));
   endfunction

   logic [PC_W-1:0]    mem [NUM_ENT];
   logic [NUM_ENT-1:0] valid_q, valid_d;
   logic               wr_rng_c, clr_rng_c, lk_rng_c;
   logic               clr_ok_c, wr_ok_c, lk_ok_c, wr_match_c, lk_hit_c;
   logic [IDX_W-1:0]   wr_idx_c, lk_idx_c;
   logic [PC_W-1:0]    lk_pos_c;
   logic [PC_W-1:0]    branch_pos_q;
   logic               branch_valid_q, branch_hit_q;
   logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;

   // Bank-number range checks only exist when NUM_PROG leaves unused codes
   generate
      if (NUM_PROG == 2 ** PROG_W) begin : g_full_range
         assign wr_rng_c  = 1'b1;
         assign clr_rng_c = 1'b1;
         assign lk_rng_c  = 1'b1;
      end else begin : g_part_range
         assign wr_rng_c  = 32'(bus.wr_prog) < NUM_PROG;
         assign clr_rng_c = 32'(bus.clr_prog) < NUM_PROG;
         assign lk_rng_c  = 32'(bus.program_num) < NUM_PROG;
      end
   endgenerate

   // Resolve this cycle's update and evaluate the lookup against its result
   always_comb begin
      clr_ok_c   = bus.clr_en && clr_rng_c;
      wr_ok_c    = bus.wr_en && wr_rng_c && !(clr_ok_c && (bus.clr_prog == bus.wr_prog));
      lk_ok_c    = lk_rng_c && !(clr_ok_c && (bus.clr_prog == bus.program_num));
      wr_idx_c   = ent_idx(bus.wr_prog, bus.wr_key);
      lk_idx_c   = ent_idx(bus.program_num, bus.key);
      wr_match_c = wr_ok_c && (wr_idx_c == lk_idx_c);
      lk_hit_c   = lk_ok_c && (wr_match_c || valid_q[lk_idx_c]);
      lk_pos_c   = wr_match_c ? bus.wr_pos : mem[lk_idx_c];
   end

   always_comb begin
      valid_d = valid_q;
      if (clr_ok_c) begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            valid_d[ent_idx(bus.clr_prog, KEY_W'(k))] = 1'b0;
         end
      end
      if (wr_ok_c) valid_d[wr_idx_c] = 1'b1;
   end

   // Target storage carries no reset; the valid bits decide what is visible
   always_ff @(posedge clk) begin
      if (wr_ok_c) mem[wr_idx_c] <= bus.wr_pos;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q        <= '0;
         branch_pos_q   <= DEFAULT_POS;
         branch_valid_q <= 1'b0;
         branch_hit_q   <= 1'b0;
         hit_cnt_q      <= '0;
         miss_cnt_q     <= '0;
      end else begin
         valid_q        <= valid_d;
         branch_valid_q <= bus.lookup_en;
         branch_hit_q   <= bus.lookup_en && lk_hit_c;
         branch_pos_q   <= (bus.lookup_en && lk_hit_c) ? lk_pos_c : DEFAULT_POS;
         if (bus.stat_clr) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
         end else if (bus.lookup_en) begin
            if (lk_hit_c) begin
               if (hit_cnt_q != CNT_MAX) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            end else begin
               if (miss_cnt_q != CNT_MAX) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   assign bus.branch_pos   = branch_pos_q;
   assign bus.branch_valid = branch_valid_q;
   assign bus.branch_hit   = branch_hit_q;
   assign bus.hit_cnt      = hit_cnt_q;
   assign bus.miss_cnt     = miss_cnt_q;
endmodule

// File: tb/tb_branch_target_table.sv
// Directed bench for branch_target_table: a vector table for lookups, bypass
// and clears, then hand-written counter-saturation and reset sequences.
module tb_branch_target_table;
   localparam int unsigned PC_W     = 12;
   localparam int unsigned KEY_W    = 5;
   localparam int unsigned NUM_PROG = 4;
   localparam int unsigned PROG_W   = 2;
   localparam int unsigned CNT_W    = 4;
   localparam int          CNT_MAX  = 15;

   typedef struct {
      bit wr;  int wp; int wk; int wpos;
      bit clr; int cp;
      bit lk;  int lp; int lkey;
      bit ev;  bit eh; int ep;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   hit_e    = 0;
   int   miss_e   = 0;
   vec_t vecs[$];

   branch_target_table_if #(.PC_W(PC_W), .KEY_W(KEY_W), .PROG_W(PROG_W), .CNT_W(CNT_W)) bus ();

   branch_target_table #(
      .PC_W(PC_W), .KEY_W(KEY_W), .NUM_PROG(NUM_PROG), .DEFAULT_POS('0), .CNT_W(CNT_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(bit wr, int wp, int wk, int wpos, bit clr, int cp,
                               bit lk, int lp, int lkey, bit ev, bit eh, int ep);
      vec_t v;
      v.wr = wr; v.wp = wp; v.wk = wk; v.wpos = wpos;
      v.clr = clr; v.cp = cp;
      v.lk = lk; v.lp = lp; v.lkey = lkey;
      v.ev = ev; v.eh = eh; v.ep = ep;
      return v;
   endfunction

   task automatic idle();
      bus.lookup_en = 1'b0; bus.program_num = '0; bus.key = '0;
      bus.wr_en = 1'b0; bus.wr_prog = '0; bus.wr_key = '0; bus.wr_pos = '0;
      bus.clr_en = 1'b0; bus.clr_prog = '0; bus.stat_clr = 1'b0;
   endtask

   task automatic drive(input vec_t v);
      bus.wr_en = v.wr; bus.wr_prog = PROG_W'(v.wp); bus.wr_key = KEY_W'(v.wk);
      bus.wr_pos = PC_W'(v.wpos);
      bus.clr_en = v.clr; bus.clr_prog = PROG_W'(v.cp);
      bus.lookup_en = v.lk; bus.program_num = PROG_W'(v.lp); bus.key = KEY_W'(v.lkey);
   endtask

   task automatic count(input bit lk, input bit hit);
      if (lk && hit && hit_e < CNT_MAX) hit_e++;
      if (lk && !hit && miss_e < CNT_MAX) miss_e++;
   endtask

   task automatic check_out(input string tag, input bit ev, input bit eh, input int ep);
      chk({tag, " branch_valid"}, int'(bus.branch_valid), int'(ev));
      chk({tag, " branch_hit"}, int'(bus.branch_hit), int'(eh));
      chk({tag, " branch_pos"}, int'(bus.branch_pos), ep);
      chk({tag, " hit_cnt"}, int'(bus.hit_cnt), hit_e);
      chk({tag, " miss_cnt"}, int'(bus.miss_cnt), miss_e);
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_out("reset", 1'b0, 1'b0, 0);
      @(negedge clk) rst_n = 1'b1;

      // wr(prog,key,pos)  clr(prog)  lookup(prog,key)  -> valid hit pos
      vecs.push_back(mk(0,0,0,0,     0,0, 1,1,3,  1,0,0));
      vecs.push_back(mk(1,2,13,83,   0,0, 0,0,0,  0,0,0));
      vecs.push_back(mk(1,1,13,16,   0,0, 0,0,0,  0,0,0));
      vecs.push_back(mk(0,0,0,0,     0,0, 1,2,13, 1,1,83));
      vecs.push_back(mk(0,0,0,0,     0,0, 1,1,13, 1,1,16));
      vecs.push_back(mk(0,0,0,0,     0,0, 1,3,13, 1,0,0));
      vecs.push_back(mk(1,1,2,69,    0,0, 1,1,2,  1,1,69));
      vecs.push_back(mk(0,0,0,0,     0,0, 1,1,2,  1,1,69));
      vecs.push_back(mk(1,1,0,100,   0,0, 0,0,0,  0,0,0));
      vecs.push_back(mk(1,1,31,200,  0,0, 1,1,13, 1,1,16));
      vecs.push_back(mk(1,1,0,55,    1,1, 1,1,0,  1,0,0));
      vecs.push_back(mk(0,0,0,0,     0,0, 1,1,0,  1,0,0));
      vecs.push_back(mk(0,0,0,0,     0,0, 1,1,31, 1,0,0));
      vecs.push_back(mk(0,0,0,0,     0,0, 1,1,13, 1,0,0));
      vecs.push_back(mk(1,2,5,300,   1,1, 1,2,5,  1,1,300));
      vecs.push_back(mk(0,0,0,0,     0,0, 1,2,5,  1,1,300));
      vecs.push_back(mk(0,0,0,0,     0,0, 1,2,13, 1,1,83));
      vecs.push_back(mk(1,1,0,9,     0,0, 0,0,0,  0,0,0));
      vecs.push_back(mk(0,0,0,0,     0,0, 1,1,0,  1,1,9));
      vecs.push_back(mk(0,0,0,0,     0,0, 1,1,2,  1,0,0));
      vecs.push_back(mk(0,0,0,0,     0,0, 1,2,13, 1,1,83));
      vecs.push_back(mk(0,0,0,0,     0,0, 1,2,5,  1,1,300));
      vecs.push_back(mk(0,0,0,0,     0,0, 1,1,0,  1,1,9));
      vecs.push_back(mk(0,0,0,0,     0,0, 1,3,1,  1,0,0));
      vecs.push_back(mk(0,0,0,0,     0,0, 1,2,13, 1,1,83));
      vecs.push_back(mk(0,0,0,0,     0,0, 0,0,0,  0,0,0));
      vecs.push_back(mk(0,0,0,0,     1,2, 1,2,13, 1,0,0));
      vecs.push_back(mk(0,0,0,0,     0,0, 1,2,5,  1,0,0));

      foreach (vecs[i]) begin
         drive(vecs[i]);
         @(posedge clk);
         #1;
         count(vecs[i].lk, vecs[i].eh);
         check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eh, vecs[i].ep);
      end
      idle();

      // 20 misses: miss counter must stop at its maximum
      for (int i = 0; i < 20; i++) begin
         bus.lookup_en = 1'b1; bus.program_num = PROG_W'(3); bus.key = KEY_W'(i);
         @(posedge clk);
         #1 count(1'b1, 1'b0);
      end
      check_out("saturate", 1'b1, 1'b0, 0);

      // stat_clr beats the increment of a same-cycle lookup
      bus.program_num = PROG_W'(1); bus.key = KEY_W'(0); bus.stat_clr = 1'b1;
      @(posedge clk);
      #1 hit_e = 0; miss_e = 0;
      check_out("stat_clr", 1'b1, 1'b1, 9);
      bus.stat_clr = 1'b0;
      @(posedge clk);
      #1 count(1'b1, 1'b1);
      check_out("post_clr", 1'b1, 1'b1, 9);

      // Reset arrives after the request is presented but before its edge
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1 hit_e = 0; miss_e = 0;
      check_out("rst_inflight", 1'b0, 1'b0, 0);
      idle();
      @(negedge clk) rst_n = 1'b1;

      // Valid bits were wiped, so the old entry now misses
      bus.lookup_en = 1'b1; bus.program_num = PROG_W'(1); bus.key = KEY_W'(0);
      @(posedge clk);
      #1 count(1'b1, 1'b0);
      check_out("after_rst", 1'b1, 1'b0, 0);

      // A visible result is dropped asynchronously by reset
      bus.wr_en = 1'b1; bus.wr_prog = PROG_W'(2); bus.wr_key = KEY_W'(4); bus.wr_pos = PC_W'(44);
      bus.program_num = PROG_W'(2); bus.key = KEY_W'(4);
      @(posedge clk);
      #1 count(1'b1, 1'b1);
      check_out("pre_async", 1'b1, 1'b1, 44);
      idle();
      #2 rst_n = 1'b0;
      #1 hit_e = 0; miss_e = 0;
      check_out("async_rst", 1'b0, 1'b0, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
